// File: rtl/hr_lut_fetch_ctrl.sv
// hr_lut_fetch_ctrl: heart-rate LUT fetch sequencer and memory-port arbiter.
// On START it reads a 2-byte BCD LUT entry (low byte at even address, high
// byte at odd address). It optionally writes both bytes to the output
// registers, then returns {hi,lo} on RESULT. While a fetch is in flight the
// CPU is stalled and its writes are blocked.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   START, IDX            fetch request and LUT index (sampled in IDLE)
//   CPU_ADDR/DATA/MW      CPU side of the shared memory port
//   CPU_Q, CPU_STALL      read data pass-through, stall while sequencer owns port
//   MEM_ADDR/DATA/MW/Q    memory side of the port (MEM_Q is combinational)
//   BUSY, DONE, ERR       status: not idle, completion pulse, range-error pulse
//   RESULT                {hi,lo} of the last successful fetch
module hr_lut_fetch_ctrl #(
  parameter logic [7:0] LUT_BASE    = 8'd0,
  parameter logic [4:0] MAX_IDX     = 5'd29,
  parameter logic [7:0] OUT_LO_ADDR = 8'd252,
  parameter logic [7:0] OUT_HI_ADDR = 8'd253,
  parameter bit         WRITE_OUT   = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [4:0]  IDX,
  input  logic [7:0]  CPU_ADDR,
  input  logic [7:0]  CPU_DATA,
  input  logic        CPU_MW,
  output logic [7:0]  CPU_Q,
  output logic        CPU_STALL,
  output logic [7:0]  MEM_ADDR,
  output logic [7:0]  MEM_DATA,
  output logic        MEM_MW,
  input  logic [7:0]  MEM_Q,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [15:0] RESULT
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRdLo = 3'd1;
  localparam logic [2:0] StRdHi = 3'd2;
  localparam logic [2:0] StWrLo = 3'd3;
  localparam logic [2:0] StWrHi = 3'd4;
  localparam logic [2:0] StFin  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] result_q, result_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [7:0]  lut_addr;
  logic        mem_mw_raw;

  // Entry address is 8-bit and wraps mod 256.
  assign lut_addr = LUT_BASE + {2'b00, idx_q, 1'b0};

  // Next-state logic. RESULT is loaded on entry to FIN so it is already
  // valid in the cycle DONE is high.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (START) begin
          if (IDX <= MAX_IDX) begin
            idx_d   = IDX;
            state_d = StRdLo;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRdLo: begin
        lo_d    = MEM_Q;
        state_d = StRdHi;
      end
      StRdHi: begin
        hi_d = MEM_Q;
        if (WRITE_OUT) begin
          state_d = StWrLo;
        end else begin
          state_d  = StFin;
          done_d   = 1'b1;
          result_d = {MEM_Q, lo_q};
        end
      end
      StWrLo: state_d = StWrHi;
      StWrHi: begin
        state_d  = StFin;
        done_d   = 1'b1;
        result_d = {hi_q, lo_q};
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Port mux depends only on the state register, never on START.
  always_comb begin
    MEM_ADDR   = CPU_ADDR;
    MEM_DATA   = CPU_DATA;
    mem_mw_raw = CPU_MW;
    case (state_q)
      StIdle: begin
        MEM_ADDR   = CPU_ADDR;
        MEM_DATA   = CPU_DATA;
        mem_mw_raw = CPU_MW;
      end
      StRdLo: begin
        MEM_ADDR   = lut_addr;
        MEM_DATA   = 8'h00;
        mem_mw_raw = 1'b0;
      end
      StRdHi: begin
        MEM_ADDR   = lut_addr + 8'd1;
        MEM_DATA   = 8'h00;
        mem_mw_raw = 1'b0;
      end
      StWrLo: begin
        MEM_ADDR   = OUT_LO_ADDR;
        MEM_DATA   = lo_q;
        mem_mw_raw = 1'b1;
      end
      StWrHi: begin
        MEM_ADDR   = OUT_HI_ADDR;
        MEM_DATA   = hi_q;
        mem_mw_raw = 1'b1;
      end
      default: begin
        MEM_ADDR   = lut_addr;
        MEM_DATA   = 8'h00;
        mem_mw_raw = 1'b0;
      end
    endcase
  end

  // Reset blocks memory writes immediately, even mid-operation.
  assign MEM_MW    = mem_mw_raw & ~RESET;
  assign CPU_Q     = MEM_Q;
  assign BUSY      = (state_q != StIdle);
  assign CPU_STALL = (state_q != StIdle);
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign RESULT    = result_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      idx_q    <= 5'd0;
      lo_q     <= 8'h00;
      hi_q     <= 8'h00;
      result_q <= 16'h0000;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_hr_lut_fetch_ctrl.sv
module tb_hr_lut_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, mem_clr;
  logic        start, start_b;
  logic [4:0]  idx;
  logic [7:0]  cpu_addr, cpu_data;
  logic        cpu_mw;

  logic [7:0]  cpu_q, mem_addr, mem_data, mem_q;
  logic        cpu_stall, mem_mw, busy, done, err;
  logic [15:0] result;

  logic [7:0]  cpu_q_b, mem_addr_b, mem_data_b, mem_q_b;
  logic        cpu_stall_b, mem_mw_b, busy_b, done_b, err_b;
  logic [15:0] result_b;

  logic [7:0]  ram   [256];
  logic [7:0]  ram_b [256];

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  // LUT contents in decimal; entries 0, 13 and 29 are pinned.
  function automatic int lut_dec(input int i);
    case (i)
      0:       return 0;
      13:      return 125;
      29:      return 259;
      default: return i * 8 + 3;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'h0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] rom_byte(input logic [7:0] a);
    logic [15:0] w;
    w = to_bcd(lut_dec(int'(a[7:1])));
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  // Bytes 0..59 are the read-only LUT; everything else is RAM.
  assign mem_q   = (mem_addr < 8'd60) ? rom_byte(mem_addr) : ram[mem_addr];
  assign mem_q_b = (mem_addr_b < 8'd60) ? rom_byte(mem_addr_b) : ram_b[mem_addr_b];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        ram[i]   <= 8'h00;
        ram_b[i] <= 8'h00;
      end
    end else begin
      if (mem_mw)   ram[mem_addr]     <= mem_data;
      if (mem_mw_b) ram_b[mem_addr_b] <= mem_data_b;
    end
  end

  hr_lut_fetch_ctrl u_dut (
    .CLK(clk), .RESET(rst), .START(start), .IDX(idx),
    .CPU_ADDR(cpu_addr), .CPU_DATA(cpu_data), .CPU_MW(cpu_mw),
    .CPU_Q(cpu_q), .CPU_STALL(cpu_stall),
    .MEM_ADDR(mem_addr), .MEM_DATA(mem_data), .MEM_MW(mem_mw), .MEM_Q(mem_q),
    .BUSY(busy), .DONE(done), .ERR(err), .RESULT(result)
  );

  hr_lut_fetch_ctrl #(.WRITE_OUT(1'b0)) u_dut_b (
    .CLK(clk), .RESET(rst), .START(start_b), .IDX(idx),
    .CPU_ADDR(cpu_addr), .CPU_DATA(cpu_data), .CPU_MW(cpu_mw),
    .CPU_Q(cpu_q_b), .CPU_STALL(cpu_stall_b),
    .MEM_ADDR(mem_addr_b), .MEM_DATA(mem_data_b), .MEM_MW(mem_mw_b), .MEM_Q(mem_q_b),
    .BUSY(busy_b), .DONE(done_b), .ERR(err_b), .RESULT(result_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WRITE_OUT=1 fetch, checked cycle by cycle. Cycle c is the c-th
  // negedge after the edge that samples START.
  task automatic run_fetch(input logic [4:0] i, input bit cpu_hold, input bit repulse);
    logic [7:0]  la;
    logic [15:0] ev;
    int          n_done;
    la     = {2'b00, i, 1'b0};
    ev     = to_bcd(lut_dec(int'(i)));
    n_done = 0;
    exp_q.push_back(ev);
    @(negedge clk);
    start = 1'b1;
    idx   = i;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) chk("addr_rd_lo", 32'(mem_addr), 32'(la));
      if (c == 2) chk("addr_rd_hi", 32'(mem_addr), 32'(la + 8'd1));
      if (c == 3) chk("addr_wr_lo", 32'(mem_addr), 32'd252);
      if (c == 4) chk("addr_wr_hi", 32'(mem_addr), 32'd253);
      if (c == 3) chk("data_wr_lo", 32'(mem_data), 32'(ev[7:0]));
      if (c == 4) chk("data_wr_hi", 32'(mem_data), 32'(ev[15:8]));
      if (c <= 5) chk("mem_mw", 32'(mem_mw), 32'(c == 3 || c == 4));
      else        chk("mem_mw_idle", 32'(mem_mw), 32'(cpu_hold));
      chk("stall", 32'(cpu_stall), 32'(c <= 5));
      chk("busy", 32'(busy), 32'(c <= 5));
      chk("done", 32'(done), 32'(c == 5));
      chk("err_quiet", 32'(err), 32'd0);
      if (cpu_hold) chk("cpu_write_blocked", 32'(ram[100]), 32'h a5);
      if (done) begin
        n_done++;
        chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("result", 32'(result), 32'(exp_q.pop_front()));
      end
      start = repulse && (c == 2 || c == 5);
      if (cpu_hold && c == 1) begin
        cpu_addr = 8'd100;
        cpu_data = 8'h5a;
        cpu_mw   = 1'b1;
      end
    end
    chk("done_count", 32'(n_done), 32'd1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("iod", 32'(ram[252]), 32'(ev[7:0]));
    chk("ioe", 32'(ram[253]), 32'(ev[15:8]));
    chk("result_hold", 32'(result), 32'(ev));
    if (cpu_hold) begin
      @(negedge clk);
      chk("cpu_write_after_fetch", 32'(ram[100]), 32'h5a);
      cpu_mw = 1'b0;
    end
  endtask

  initial begin
    rst      = 1'b1;
    mem_clr  = 1'b1;
    start    = 1'b0;
    start_b  = 1'b0;
    idx      = 5'd0;
    cpu_addr = 8'd100;
    cpu_data = 8'hff;
    cpu_mw   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Reset state, and reset gating the CPU write path.
    chk("rst_mw_forced", 32'(mem_mw), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_result_b", 32'(result_b), 32'd0);
    cpu_mw  = 1'b0;
    mem_clr = 1'b0;
    rst     = 1'b0;

    // CPU write while idle.
    @(negedge clk);
    cpu_data = 8'ha5;
    cpu_mw   = 1'b1;
    #1;
    chk("idle_mw_pass", 32'(mem_mw), 32'd1);
    chk("idle_addr_pass", 32'(mem_addr), 32'd100);
    @(negedge clk);
    cpu_mw = 1'b0;
    chk("idle_write", 32'(ram[100]), 32'ha5);
    chk("cpu_q_pass", 32'(cpu_q), 32'ha5);

    run_fetch(5'd13, 1'b0, 1'b0);
    run_fetch(5'd0, 1'b0, 1'b0);
    run_fetch(5'd29, 1'b0, 1'b0);

    // Out-of-range index.
    @(negedge clk);
    start = 1'b1;
    idx   = 5'd30;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_mw", 32'(mem_mw), 32'd0);
    chk("err_no_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("err_one_cycle", 32'(err), 32'd0);
    chk("err_busy2", 32'(busy), 32'd0);
    chk("err_result_kept", 32'(result), 32'h0259);

    // CPU write held across a fetch.
    run_fetch(5'd13, 1'b1, 1'b0);

    // Reset in RD_HI aborts the fetch.
    @(negedge clk);
    start = 1'b1;
    idx   = 5'd29;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_addr_rd_hi", 32'(mem_addr), 32'd59);
    rst = 1'b1;
    #1;
    chk("abort_mw", 32'(mem_mw), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    for (int c = 0; c < 5; c++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_no_mw", 32'(mem_mw), 32'd0);
      @(negedge clk);
    end
    chk("abort_iod", 32'(ram[252]), 32'h25);
    chk("abort_ioe", 32'(ram[253]), 32'h01);

    // START re-pulsed mid-fetch and in FIN.
    run_fetch(5'd29, 1'b0, 1'b1);

    // WRITE_OUT=0 instance.
    @(negedge clk);
    start_b = 1'b1;
    idx     = 5'd13;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      chk("b_done", 32'(done_b), 32'(c == 3));
      chk("b_busy", 32'(busy_b), 32'(c <= 3));
      chk("b_mw", 32'(mem_mw_b), 32'd0);
      if (c == 3) chk("b_result", 32'(result_b), 32'h0125);
    end
    chk("b_no_iod", 32'(ram_b[252]), 32'd0);
    chk("b_no_ioe", 32'(ram_b[253]), 32'd0);
    chk("b_result_hold", 32'(result_b), 32'h0125);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
